// File: rtl/cl_frame_gen.sv
// cl_frame_gen
// ------------
// Camera Link frame generator. Drives FVAL/LVAL and an 8-tap x 10-bit pixel
// bus carrying a deterministic ramp, with programmable geometry and blanking.
// It stands in for a camera on the test/loopback path.
//
// Optional feature (compile-time macro CL_GEN_LINE_HDR_EN):
//   defined     -> clock 0 of every line carries {48'h0, frame_num, line_num}
//   not defined -> clock 0 carries the ramp like every other clock
//
// Ports:
//   cl_clk      in   pixel clock
//   reset       in   asynchronous, active-high
//   start       in   one-cycle request to begin generation (IDLE only)
//   stop        in   one-cycle request: finish current frame, then IDLE
//   num_frames  in   frames to emit, sampled with start; 0 = until stop
//   cl_fval     out  frame valid
//   cl_lval     out  line valid
//   cl_data     out  tap k at bits [10k+9:10k], k = 0..7
//   frame_num   out  completed-frame count since reset (wraps)
//   frame_done  out  one-cycle pulse on the clock FVAL falls
//   busy        out  high whenever the generator is not idle
//
// start/stop are plain level-sampled request pulses: each is acted on at the
// rising cl_clk edge where it is high; there is no acknowledge.
module cl_frame_gen #(
  parameter int CLKS_PER_LINE   = 256,
  parameter int LINES_PER_FRAME = 2048,
  parameter int FV2LV           = 4,
  parameter int HBLANK          = 16,
  parameter int LV2FV           = 4,
  parameter int VBLANK          = 64,
  parameter int FRAME_NUM_SIZE  = 20,
  parameter int LINE_NUM_SIZE   = 12,
  parameter int CLK_COUNT_SIZE  = 10
) (
  input  logic                      cl_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic [15:0]               num_frames,
  output logic                      cl_fval,
  output logic                      cl_lval,
  output logic [79:0]               cl_data,
  output logic [FRAME_NUM_SIZE-1:0] frame_num,
  output logic                      frame_done,
  output logic                      busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FV_LEAD, S_LINE, S_HGAP, S_FV_TRAIL, S_VGAP
  } state_t;

  state_t                    state_q, state_d;
  // Clocks already spent in the current state; wide enough for any blanking.
  logic [31:0]               cnt_q, cnt_d;
  logic [LINE_NUM_SIZE-1:0]  line_q, line_d;
  logic [15:0]               num_frames_q, num_frames_d;
  logic [15:0]               frm_cnt_q, frm_cnt_d;
  logic                      stop_lat_q, stop_lat_d;
  logic                      done_q, done_d;
  logic                      fval_q, fval_d;
  logic                      lval_q, lval_d;
  logic [79:0]               data_q, data_d;
  logic [FRAME_NUM_SIZE-1:0] frame_num_q, frame_num_d;
  logic                      frame_done_q, frame_done_d;
  logic                      busy_q, busy_d;

  logic [CLK_COUNT_SIZE-1:0] clk_idx;
  logic [9:0]                f10, l10, c8;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    num_frames_d = num_frames_q;
    frm_cnt_d    = frm_cnt_q;
    stop_lat_d   = stop_lat_q;
    done_d       = done_q;
    frame_num_d  = frame_num_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_FV_LEAD;
          cnt_d        = '0;
          line_d       = '0;
          num_frames_d = num_frames;
          frm_cnt_d    = '0;
          // A stop arriving together with start makes this a one-frame run.
          stop_lat_d   = stop;
          done_d       = 1'b0;
        end
      end
      S_FV_LEAD: begin
        if (cnt_q == 32'(FV2LV - 1)) begin
          state_d = S_LINE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_LINE: begin
        if (cnt_q == 32'(CLKS_PER_LINE - 1)) begin
          cnt_d = '0;
          if (line_q == LINE_NUM_SIZE'(LINES_PER_FRAME - 1)) begin
            state_d = S_FV_TRAIL;
          end else begin
            state_d = S_HGAP;
            line_d  = line_q + LINE_NUM_SIZE'(1);
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_HGAP: begin
        if (cnt_q == 32'(HBLANK - 1)) begin
          state_d = S_LINE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_FV_TRAIL: begin
        if (cnt_q == 32'(LV2FV - 1)) begin
          state_d      = S_VGAP;
          cnt_d        = '0;
          frame_done_d = 1'b1;
          frame_num_d  = frame_num_q + FRAME_NUM_SIZE'(1);
          frm_cnt_d    = frm_cnt_q + 16'd1;
          // The run-length decision is taken once, as FVAL falls.
          done_d       = stop_lat_q || stop ||
                         (num_frames_q != 16'd0 && (frm_cnt_q + 16'd1) == num_frames_q);
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_VGAP: begin
        if (cnt_q == 32'(VBLANK - 1)) begin
          cnt_d  = '0;
          line_d = '0;
          if (done_q) begin
            state_d    = S_IDLE;
            stop_lat_d = 1'b0;
            done_d     = 1'b0;
          end else begin
            state_d = S_FV_LEAD;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stop requests are remembered for the rest of the run; in IDLE they are
    // only meaningful alongside start (handled above).
    if (state_q != S_IDLE && state_d != S_IDLE && stop) stop_lat_d = 1'b1;
  end

  // Output image is computed from the next state so every output is a flop.
  assign clk_idx = cnt_d[CLK_COUNT_SIZE-1:0];
  assign f10     = 10'(frame_num_q);
  assign l10     = 10'(line_d);
  assign c8      = 10'({clk_idx, 3'b000});

  always_comb begin
    fval_d = (state_d == S_FV_LEAD) || (state_d == S_LINE) ||
             (state_d == S_HGAP)    || (state_d == S_FV_TRAIL);
    lval_d = (state_d == S_LINE);
    busy_d = (state_d != S_IDLE);
    data_d = '0;
    if (state_d == S_LINE) begin
      for (int k = 0; k < 8; k++) begin
        data_d[10*k +: 10] = f10 + l10 + c8 + 10'(k);
      end
`ifdef CL_GEN_LINE_HDR_EN
      if (cnt_d == 32'd0) begin
        data_d = {48'h0, 20'(frame_num_q), 12'(line_d)};
      end
`endif
    end
  end

  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      line_q       <= '0;
      num_frames_q <= '0;
      frm_cnt_q    <= '0;
      stop_lat_q   <= 1'b0;
      done_q       <= 1'b0;
      fval_q       <= 1'b0;
      lval_q       <= 1'b0;
      data_q       <= '0;
      frame_num_q  <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      num_frames_q <= num_frames_d;
      frm_cnt_q    <= frm_cnt_d;
      stop_lat_q   <= stop_lat_d;
      done_q       <= done_d;
      fval_q       <= fval_d;
      lval_q       <= lval_d;
      data_q       <= data_d;
      frame_num_q  <= frame_num_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign cl_fval    = fval_q;
  assign cl_lval    = lval_q;
  assign cl_data    = data_q;
  assign frame_num  = frame_num_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cl_frame_gen.sv
// Bench for cl_frame_gen with a small geometry. A timeline model derives the
// expected outputs from the frame schedule; directed tests add literal checks.
module tb_cl_frame_gen;

  localparam int CPL      = 4;
  localparam int LPF      = 3;
  localparam int FV2LV    = 2;
  localparam int HB       = 1;
  localparam int LV2FV    = 2;
  localparam int VB       = 3;
  localparam int FVAL_LEN = FV2LV + LPF*CPL + (LPF-1)*HB + LV2FV;
  localparam int PERIOD   = FVAL_LEN + VB;

  // ---------------- clock / reset ----------------
  logic        cl_clk = 1'b0;
  logic        reset  = 1'b1;
  logic        start  = 1'b0;
  logic        stop   = 1'b0;
  logic [15:0] num_frames = 16'd0;
  logic        cl_fval, cl_lval, frame_done, busy;
  logic [79:0] cl_data;
  logic [19:0] frame_num;

  always #5 cl_clk = ~cl_clk;

  cl_frame_gen #(
    .CLKS_PER_LINE(CPL), .LINES_PER_FRAME(LPF), .FV2LV(FV2LV), .HBLANK(HB),
    .LV2FV(LV2FV), .VBLANK(VB), .FRAME_NUM_SIZE(20), .LINE_NUM_SIZE(12),
    .CLK_COUNT_SIZE(10)
  ) dut (
    .cl_clk(cl_clk), .reset(reset), .start(start), .stop(stop),
    .num_frames(num_frames), .cl_fval(cl_fval), .cl_lval(cl_lval),
    .cl_data(cl_data), .frame_num(frame_num), .frame_done(frame_done),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- timeline model ----------------
  logic m_active = 1'b0;
  int   m_t      = 0;   // clocks since the current frame's FVAL rose
  int   m_f      = 0;   // frame_num value when the current frame started
  int   m_fnum   = 0;
  int   m_emit   = 0;
  int   m_num    = 0;
  logic m_stop   = 1'b0;
  logic m_done   = 1'b0;

  always @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0; m_t = 0; m_f = 0; m_fnum = 0; m_emit = 0;
      m_num = 0; m_stop = 1'b0; m_done = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_t = 0; m_num = int'(num_frames); m_emit = 0;
        m_stop = stop; m_done = 1'b0; m_f = m_fnum;
      end
    end else begin
      if (stop) m_stop = 1'b1;
      m_t++;
      if (m_t == FVAL_LEN) begin
        m_fnum = (m_fnum + 1) % (1 << 20);
        m_emit++;
        m_done = m_stop || (m_num != 0 && m_emit == m_num);
      end
      if (m_t == PERIOD) begin
        if (m_done) begin
          m_active = 1'b0; m_stop = 1'b0; m_done = 1'b0;
        end else begin
          m_t = 0; m_f = m_fnum;
        end
      end
    end
  end

  function automatic logic [79:0] pix(input int f, input int l, input int c);
    logic [79:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[10*k +: 10] = 10'((f + l + 8*c + k) % 1024);
`ifdef CL_GEN_LINE_HDR_EN
    if (c == 0) d = {48'h0, 20'(f), 12'(l)};
`endif
    return d;
  endfunction

  // ---------------- per-cycle scoreboard ----------------
  always @(negedge cl_clk) begin
    logic        e_fval, e_lval, e_done, e_busy;
    logic [79:0] e_data;
    int          u, l, c;
    e_fval = 1'b0; e_lval = 1'b0; e_done = 1'b0; e_busy = m_active; e_data = '0;
    if (m_active) begin
      if (m_t < FVAL_LEN) begin
        e_fval = 1'b1;
        u = m_t - FV2LV;
        if (u >= 0 && u < LPF*(CPL+HB) - HB) begin
          l = u / (CPL+HB);
          c = u % (CPL+HB);
          if (c < CPL) begin
            e_lval = 1'b1;
            e_data = pix(m_f, l, c);
          end
        end
      end
      e_done = (m_t == FVAL_LEN);
    end
    n_checks++;
    if ({cl_fval, cl_lval, frame_done, busy, frame_num, cl_data} !==
        {e_fval, e_lval, e_done, e_busy, 20'(m_fnum), e_data}) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t: got fval=%b lval=%b done=%b busy=%b fnum=%0d data=%h, expected fval=%b lval=%b done=%b busy=%b fnum=%0d data=%h",
               $time, cl_fval, cl_lval, frame_done, busy, frame_num, cl_data,
               e_fval, e_lval, e_done, e_busy, m_fnum, e_data);
    end
  end

  // ---------------- event monitor ----------------
  int   fv_cnt = 0, lv_pulses = 0, fd_cnt = 0, vg_cnt = 0;
  logic lv_prev = 1'b0;
  always @(posedge cl_clk) begin
    if (cl_fval) fv_cnt++;
    if (cl_lval && !lv_prev) lv_pulses++;
    lv_prev = cl_lval;
    if (frame_done) fd_cnt++;
    if (busy && !cl_fval) vg_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge cl_clk);
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1; tick(2); reset = 1'b0; tick(1);
  endtask

  task automatic clr_mon;
    fv_cnt = 0; lv_pulses = 0; fd_cnt = 0; vg_cnt = 0;
  endtask

  // After return the negedge following the sampling edge has passed (t = 0).
  task automatic pulse_start(input logic [15:0] nf, input logic stp);
    num_frames = nf; start = 1'b1; stop = stp;
    tick(1);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin tick(1); n++; end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    tick(1);
    check("reset_outputs", {56'h0, cl_fval, cl_lval, frame_done, busy, frame_num},
          80'h0);
    do_reset();

    // Single frame: geometry, blanking and pattern.
    clr_mon();
    pulse_start(16'd1, 1'b0);
    check("start_fval_busy", {78'h0, cl_fval, busy}, 80'h3);
    tick(6);
    check("hgap_data_zero", {cl_lval, cl_data[78:0]}, 80'h0);
    tick(3);
    check("f0_l1_c2_taps", cl_data,
          {10'd24, 10'd23, 10'd22, 10'd21, 10'd20, 10'd19, 10'd18, 10'd17});
    wait_idle("single_frame_idle", 100);
    tick(2);
    check("fval_high_clocks", 80'(fv_cnt), 80'd18);
    check("lval_pulses", 80'(lv_pulses), 80'd3);
    check("frame_done_count", 80'(fd_cnt), 80'd1);
    check("vgap_busy_clocks", 80'(vg_cnt), 80'd3);
    check("frame_num_one", 80'(frame_num), 80'd1);

    // Free-running, stop mid-line of frame 2.
    do_reset();
    clr_mon();
    pulse_start(16'd0, 1'b0);
    tick(44);
    check("frame2_in_line", {79'h0, cl_lval}, 80'h1);
    stop = 1'b1; tick(1); stop = 1'b0;
    wait_idle("stop_idle", 200);
    tick(2);
    check("stop_frame_num", 80'(frame_num), 80'd3);
    check("stop_frame_done_count", 80'(fd_cnt), 80'd3);

    // start+stop together, then start while busy.
    do_reset();
    clr_mon();
    pulse_start(16'd5, 1'b1);
    tick(3);
    pulse_start(16'd7, 1'b0);
    wait_idle("startstop_idle", 100);
    tick(10);
    check("startstop_frame_num", 80'(frame_num), 80'd1);
    check("startstop_done_count", 80'(fd_cnt), 80'd1);
    check("startstop_stays_idle", {79'h0, busy}, 80'h0);

    // Reset mid-line, then restart from frame 0.
    do_reset();
    pulse_start(16'd0, 1'b0);
    tick(24);
    check("pre_reset_frame_num", 80'(frame_num), 80'd1);
    check("pre_reset_lval", {79'h0, cl_lval}, 80'h1);
    clr_mon();
    #2 reset = 1'b1;
    #1 check("async_reset_outputs",
             {cl_data[75:0], cl_fval, cl_lval, frame_done, busy} |
             {60'h0, frame_num} | {76'h0, cl_data[79:76]}, 80'h0);
    tick(2);
    reset = 1'b0;
    tick(1);
    check("reset_no_frame_done", 80'(fd_cnt), 80'd0);
    pulse_start(16'd1, 1'b0);
    tick(3);
    check("restart_f0_l0_c1", cl_data,
          {10'd15, 10'd14, 10'd13, 10'd12, 10'd11, 10'd10, 10'd9, 10'd8});
    wait_idle("restart_idle", 100);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
